crc_stream_gen: RTL



---
 rtl/crc_stream_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/crc_stream_gen.sv
// crc_stream_gen
//   Streaming multi-beat CRC engine. Takes a frame of DW-bit beats over a
//   valid/ready handshake, folds BPC bits per clock into a CW-bit Galois LFSR
//   (MSB-first, optional per-byte input reflection), then presents the
//   finalised CRC (optional full reflection, XOR mask) on a valid/ready output.
//
// Ports
//   clk        in   clock
//   rst_b      in   asynchronous active-low reset
//   clr        in   synchronous abort, highest priority
//   din        in   [DW-1:0] frame beat
//   din_valid  in   beat valid
//   din_last   in   beat closes the frame (sampled with din)
//   din_ready  out  engine accepts a beat this cycle
//   crc        out  [CW-1:0] finalised CRC, stable while crc_valid
//   crc_valid  out  CRC available
//   crc_ready  in   consumer takes the CRC
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame in progress, LFSR = INIT, ready for first beat
// S_WAIT  | mid-frame, waiting for the next beat, LFSR/counter frozen
// S_SHIFT | folding the captured beat into the LFSR, BPC bits per cycle
// S_OUT   | finalised CRC presented, waiting for crc_ready

module crc_stream_gen #(
  parameter int              DW     = 8,
  parameter int              CW     = 8,
  parameter logic [CW-1:0]   POLY   = CW'(8'h07),
  parameter logic [CW-1:0]   INIT   = '0,
  parameter int              BPC    = 1,
  parameter bit              REFIN  = 1'b0,
  parameter bit              REFOUT = 1'b0,
  parameter logic [CW-1:0]   XOROUT = '0
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          din_last,
  output logic          din_ready,
  output logic [CW-1:0] crc,
  output logic          crc_valid,
  input  logic          crc_ready
);

  localparam int NSH  = DW / BPC;
  localparam int CNTW = $clog2(NSH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_lfsr;
  logic [CW-1:0]   r_crc;
  logic [DW-1:0]   r_data;
  logic [CNTW-1:0] r_cnt;
  logic            r_last;

  logic [CW-1:0]   w_lfsr_sh;
  logic [DW-1:0]   w_data_sh;

  // Reverse the bit order inside every byte, keeping byte positions, so the
  // MSB-first shifter consumes each byte LSB-first.
  function automatic logic [DW-1:0] refl_bytes(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    int            j;
    r = d;
    for (int i = 0; i < DW; i++) begin
      j = (i / 8) * 8 + 7 - (i % 8);
      if (j < DW) r[i] = d[j];
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] finalise(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    if (REFOUT) begin
      for (int i = 0; i < CW; i++) r[i] = v[CW-1-i];
    end
    return r ^ XOROUT;
  endfunction

  // BPC unrolled Galois steps; bits pushed above CW-1 fall off the shift.
  always_comb begin : p_shift
    logic fb;
    fb        = 1'b0;
    w_lfsr_sh = r_lfsr;
    w_data_sh = r_data;
    for (int i = 0; i < BPC; i++) begin
      fb        = w_data_sh[DW-1] ^ w_lfsr_sh[CW-1];
      w_lfsr_sh = (w_lfsr_sh << 1) ^ (POLY & {CW{fb}});
      w_data_sh = w_data_sh << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_lfsr  <= INIT;
      r_crc   <= finalise(INIT);
      r_data  <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_lfsr  <= INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_WAIT: begin
          if (din_valid) begin
            r_data  <= REFIN ? refl_bytes(din) : din;
            r_last  <= din_last;
            r_cnt   <= CNTW'(NSH);
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_lfsr <= w_lfsr_sh;
          r_data <= w_data_sh;
          r_cnt  <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) begin
            if (r_last) begin
              r_state <= S_OUT;
              // Finalise from the last shift so crc is valid with crc_valid.
              r_crc   <= finalise(w_lfsr_sh);
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_OUT: begin
          if (crc_ready) begin
            r_state <= S_IDLE;
            r_lfsr  <= INIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign din_ready = (r_state == S_IDLE) || (r_state == S_WAIT);
  assign crc_valid = (r_state == S_OUT);
  assign crc       = r_crc;

endmodule
